// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared constants and encodings for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_CHUNK : default operand width and per-stage slice width.
//   mode_e                : encoding of the 'sub' control input.
//   num_stages()          : pipeline depth for a given width/slice pair.
package adder_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// add_chunk
//   One registered CHUNK-bit slice of the ripple pipeline. Adds i_a + i_b +
//   i_cin and captures the slice sum, the carry out and the beat valid bit
//   when i_en is high; everything holds when i_en is low.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     i_en            : global pipeline advance
//     i_vld           : valid bit of the beat entering this slice
//     i_a, i_b, i_cin : slice operands and carry from the previous slice
//     o_vld           : registered valid
//     o_sum, o_cout   : registered slice sum and carry out
module add_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic             o_vld,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_full;
    logic           r_vld;
    logic [CHUNK-1:0] r_sum;
    logic           r_cout;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (i_en) begin
            r_vld  <= i_vld;
            r_sum  <= w_full[CHUNK-1:0];
            r_cout <= w_full[CHUNK];
        end
    end

    assign o_vld  = r_vld;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   WIDTH-bit adder/subtractor split into STAGES = WIDTH/CHUNK ripple stages.
//   Slice k is added in stage k with the carry registered by slice k-1.
//   Operand slices are delayed k cycles before their adder (skew in), and
//   slice sums are delayed STAGES-1-k cycles after it (deskew out), so a
//   whole result leaves the last stage together. A single enable
//   (adv = out_ready | ~out_valid) moves every register in lockstep.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid / in_ready   : operand handshake (in_ready == adv)
//     a, b, cin, sub        : operands, carry-in (add only), 0=add 1=sub
//     out_valid / out_ready : result handshake
//     sum, cout, ovf        : result, carry out of MSB, signed overflow
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a positive multiple of CHUNK");
    end

    logic                         w_adv;
    logic [WIDTH-1:0]             w_b_eff;
    logic                         w_cin_eff;
    logic [STAGES:0]              w_vld_pipe;
    logic [STAGES:0]              w_carry;
    logic [STAGES-1:0][CHUNK-1:0] w_op_a;
    logic [STAGES-1:0][CHUNK-1:0] w_op_b;
    logic [STAGES-1:0][CHUNK-1:0] w_sum_chunk;
    logic [STAGES-1:0][CHUNK-1:0] w_res;
    logic                         r_ab_msb;

    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // Subtract is a + ~b + 1: invert b up front and force the carry-in.
    assign w_b_eff   = (mode_e'(sub) == MODE_SUB) ? ~b : b;
    assign w_cin_eff = (mode_e'(sub) == MODE_SUB) ? 1'b1 : cin;

    assign w_vld_pipe[0] = in_valid;
    assign w_carry[0]    = w_cin_eff;

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        localparam int OP_DLY  = k;
        localparam int SUM_DLY = STAGES - 1 - k;

        // Operand skew: slice k waits k cycles so it meets its carry.
        if (OP_DLY == 0) begin : g_op_now
            assign w_op_a[k] = a[k*CHUNK +: CHUNK];
            assign w_op_b[k] = w_b_eff[k*CHUNK +: CHUNK];
        end else begin : g_op_dly
            logic [OP_DLY-1:0][2*CHUNK-1:0] r_op;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_op <= '0;
                end else if (w_adv) begin
                    r_op[0] <= {a[k*CHUNK +: CHUNK], w_b_eff[k*CHUNK +: CHUNK]};
                    for (int i = 1; i < OP_DLY; i++) begin
                        r_op[i] <= r_op[i-1];
                    end
                end
            end

            assign {w_op_a[k], w_op_b[k]} = r_op[OP_DLY-1];
        end

        add_chunk #(.CHUNK(CHUNK)) u_add (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_vld  (w_vld_pipe[k]),
            .i_a    (w_op_a[k]),
            .i_b    (w_op_b[k]),
            .i_cin  (w_carry[k]),
            .o_vld  (w_vld_pipe[k+1]),
            .o_sum  (w_sum_chunk[k]),
            .o_cout (w_carry[k+1])
        );

        // Sum deskew: finished lower slices ride along until the top one lands.
        if (SUM_DLY == 0) begin : g_sum_now
            assign w_res[k] = w_sum_chunk[k];
        end else begin : g_sum_dly
            logic [SUM_DLY-1:0][CHUNK-1:0] r_sum_dly;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum_dly <= '0;
                end else if (w_adv) begin
                    r_sum_dly[0] <= w_sum_chunk[k];
                    for (int i = 1; i < SUM_DLY; i++) begin
                        r_sum_dly[i] <= r_sum_dly[i-1];
                    end
                end
            end

            assign w_res[k] = r_sum_dly[SUM_DLY-1];
        end
    end

    // Carry into the MSB is a_msb ^ b_msb ^ sum_msb. The operand MSB parity is
    // captured alongside the final slice so it lines up with the stored sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_msb <= 1'b0;
        end else if (w_adv) begin
            r_ab_msb <= w_op_a[STAGES-1][CHUNK-1] ^ w_op_b[STAGES-1][CHUNK-1];
        end
    end

    assign out_valid = w_vld_pipe[STAGES];
    assign sum       = w_res;
    assign cout      = w_carry[STAGES];
    assign ovf       = r_ab_msb ^ w_res[STAGES-1][CHUNK-1] ^ w_carry[STAGES];

endmodule

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;

    localparam int W  = 64;
    localparam int C  = 16;
    localparam int ST = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vt[8];

    pipelined_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus the sign rule for overflow.
    // Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        logic [W:0] t;
        logic       ov;
        if (sb) begin
            t  = {1'b0, x} + {1'b0, ~y} + 65'd1;
            ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        end
        return {ov, t[W], t[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return {W{1'b1}};
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {48'd0, 16'hFFFF};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Single isolated beat: checks latency from the accepting edge and the result.
    task automatic one_beat(input vec_t v, input string nm);
        int lat;
        bit seen;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        chkb({nm, " in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 1;
        seen = 0;
        while (!seen && lat < 20) begin
            if (out_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chkb({nm, " seen"}, seen, 1'b1);
        chk({nm, " latency"}, (W+2)'(lat), (W+2)'(ST));
        chk({nm, " result"}, {ovf, cout, sum}, {v.ov, v.co, v.s});
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back, always ready; mode 1: 3-cycle stall; mode 2: random.
    task automatic run_stream(input int n, input int mode, input string nm);
        logic [W+1:0] q[$];
        logic [W+1:0] held;
        logic [W+1:0] exp;
        bit           held_v;
        bit           acc;
        int           sent, got, cyc, first, last;
        sent = 0; got = 0; cyc = 0; first = -1; last = -1; held_v = 0;
        in_valid = 1'b0;
        while (got < n && cyc < 3000) begin
            if (mode == 2)      out_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 1) out_ready = !(cyc >= 6 && cyc < 9);
            else                out_ready = 1'b1;
            if (!in_valid && sent < n && (mode < 2 || $urandom_range(0, 2) != 0)) begin
                a = rnd_op(); b = rnd_op();
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (held_v) begin
                chkb({nm, " hold valid"}, out_valid, 1'b1);
                chk({nm, " hold data"}, {ovf, cout, sum}, held);
            end
            if (out_valid && !out_ready)
                chkb({nm, " stall in_ready"}, in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk({nm, " unexpected beat"}, {ovf, cout, sum}, '0);
                end else begin
                    exp = q.pop_front();
                    chk({nm, " result"}, {ovf, cout, sum}, exp);
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            held_v = out_valid && !out_ready;
            held   = {ovf, cout, sum};
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, " delivered"}, (W+2)'(got), (W+2)'(n));
        chk({nm, " leftover"}, (W+2)'(q.size()), '0);
        if (mode == 0)
            chk({nm, " consecutive"}, (W+2)'(last - first), (W+2)'(n - 1));
    endtask

    initial begin
        int stale;
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
        vt[1] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[3] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        vt[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vt[5] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
        vt[7] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chkb("reset out_valid", out_valid, 1'b0);
        chkb("reset in_ready", in_ready, 1'b1);
        chk("reset result", {ovf, cout, sum}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) one_beat(vt[i], $sformatf("vec%0d", i));

        run_stream(10, 0, "b2b");
        run_stream(12, 1, "stall");
        run_stream(300, 2, "rand");

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rnd_op(); b = rnd_op(); cin = 1'b1; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chkb("midrst out_valid", out_valid, 1'b0);
        chkb("midrst in_ready", in_ready, 1'b1);
        chk("midrst result", {ovf, cout, sum}, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        one_beat(vt[2], "post_rst");
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst stale", (W+2)'(stale), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits added per pipeline stage; WIDTH % CHUNK == 0 is mandatory; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: operand beat accepted this cycle when high with in_valid.
REQ-007 SHALL have port a, input, WIDTH bits: first operand.
REQ-008 SHALL have port b, input, WIDTH bits: second operand.
REQ-009 SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes the result beat when high with out_valid.
REQ-013 SHALL have port sum, output, WIDTH bits: result.
REQ-014 SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 SHALL compute add as a + b + cin and subtract as a + ~b + 1, with cin ignored when sub=1.
REQ-017 SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) in stage k, using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-018 SHALL skew operands: unadded upper chunks travel with the beat in stage registers; completed lower sum chunks are carried forward.
REQ-019 SHALL set ovf = carry into MSB XOR carry out of MSB, and cout = carry out of MSB, both taken from the final stage.
REQ-020 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when no stall occurs, with throughput of one beat per cycle.
REQ-021 SHALL advance the pipeline on the global enable adv = out_ready OR NOT out_valid; in_ready SHALL equal adv.
REQ-022 SHALL keep every stage register, including its valid bit, unchanged when adv=0; sum/cout/ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL insert a bubble into stage 0 when adv=1 and in_valid=0; beats SHALL never be dropped, duplicated or reordered.
REQ-024 SHALL permit acceptance and delivery in the same cycle.
REQ-025 SHALL leave data registers of invalid stages don't-care; only valid bits are control-relevant.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid bits, so out_valid=0 and in_ready=1 while reset is held.
REQ-027 SHALL clear sum, cout and ovf to 0 on reset.
REQ-028 SHALL flush in-flight beats when reset is asserted mid-operation; no flushed beat SHALL appear after release.
REQ-029 SHALL release reset synchronously to clk externally; the block accepts a beat on the first edge after release.

Structure
REQ-030 SHALL place the default WIDTH/CHUNK constants and the add/sub mode encoding in a shared package, adder_pkg.
REQ-031 SHALL use one sub-module, add_chunk: a registered CHUNK-bit slice with carry in/out, enable and valid, instantiated STAGES times through generate.
REQ-032 SHALL have an elaboration-time check that fails when WIDTH % CHUNK != 0.

Verification (WIDTH=64, CHUNK=16)
REQ-033 SHALL cover a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0, out_valid 4 cycles after acceptance.
REQ-034 SHALL cover a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-035 SHALL cover a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-036 SHALL cover 10 back-to-back beats with out_ready=1 -> 10 results on consecutive cycles, in order, matching a reference model.
REQ-037 SHALL cover out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs held stable, all beats delivered exactly once after resume.
REQ-038 SHALL cover rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale beats after release.
